// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle sequencer placed in front of an 8-bit PWM generator.
// It accepts a target duty and ramp rate, then moves the applied duty one STEP
// toward the target every "rate" PWM periods. This gives soft start and soft stop.
// Optional abort input: define PWM_RAMP_ABORT_EN to add abort_i.
module pwm_ramp_ctrl #(
  parameter int WIDTH  = 8,
  parameter int STEP   = 1,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              ena,
  input  logic              period_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
`ifdef PWM_RAMP_ABORT_EN
  input  logic              abort_i,
`endif
  output logic [WIDTH-1:0]  duty_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DONE} state_t;

  // Step size in the widened domain, used for the distance comparison.
  localparam logic [WIDTH:0]   L_STEP_X = (WIDTH+1)'(STEP);
  // Step size at duty width; a step is taken only when the remaining distance
  // exceeds STEP, so adding or subtracting it can never wrap.
  localparam logic [WIDTH-1:0] L_STEP_N = WIDTH'(STEP);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_duty;
  logic [WIDTH-1:0]    r_target;
  logic [RATE_W-1:0]   r_rate;
  logic [RATE_W-1:0]   r_cnt;

  logic                w_abort;
  logic                w_accept;
  logic                w_tick;
  logic                w_fire;
  logic [RATE_W-1:0]   w_cap_rate;
  logic [WIDTH-1:0]    w_base;
  logic [WIDTH:0]      w_duty_x;
  logic [WIDTH:0]      w_tgt_x;
  logic [WIDTH:0]      w_diff;
  logic                w_up;
  logic [WIDTH-1:0]    w_duty_step;

`ifdef PWM_RAMP_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept   = (r_state == S_IDLE) && ena && cmd_valid;
  assign w_tick     = (r_state == S_RAMP) && ena && period_tick;
  assign w_fire     = w_tick && (r_cnt == (r_rate - RATE_W'(1)));
  assign w_cap_rate = (cmd_rate == '0) ? RATE_W'(1) : cmd_rate;
  // The duty that the captured target is compared with. An abort in the same
  // cycle zeroes the duty, so the comparison uses zero in that case.
  assign w_base     = w_abort ? '0 : r_duty;

  // Next ramp value: clamp to the target when it is within one step.
  always_comb begin
    w_duty_x = {1'b0, r_duty};
    w_tgt_x  = {1'b0, r_target};
    w_up     = (w_tgt_x > w_duty_x);
    w_diff   = w_up ? (w_tgt_x - w_duty_x) : (w_duty_x - w_tgt_x);
    if (w_diff <= L_STEP_X) begin
      w_duty_step = r_target;
    end else if (w_up) begin
      w_duty_step = r_duty + L_STEP_N;
    end else begin
      w_duty_step = r_duty - L_STEP_N;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (cmd_target == w_base) ? S_DONE : S_RAMP;
        end
      end
      S_RAMP: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
        end else if (w_fire && (w_duty_step == r_target)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Command capture, period counter and applied duty.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_duty   <= '0;
      r_target <= '0;
      r_rate   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_target <= cmd_target;
        r_rate   <= w_cap_rate;
        r_cnt    <= '0;
      end
      if (w_abort) begin
        r_duty <= '0;
      end else if (w_fire) begin
        r_duty <= w_duty_step;
        r_cnt  <= '0;
      end else if (w_tick) begin
        r_cnt  <= r_cnt + RATE_W'(1);
      end
    end
  end

  // Status and handshake outputs decoded from the state.
  always_comb begin
    cmd_ready = (r_state == S_IDLE) && ena;
    busy_o    = (r_state == S_RAMP);
    done_o    = (r_state == S_DONE);
  end

  assign duty_o = r_duty;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: three instances with STEP = 1, 8 and 16 share the
// clock, reset, enable and period tick. Expected duty changes are queued when a
// command is issued and popped as the active instance changes duty.
// Define PWM_RAMP_ABORT_EN to include the abort scenario.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       ena;
  logic       period_tick;
  logic       cmd_valid  [3];
  logic       cmd_ready  [3];
  logic [7:0] cmd_target [3];
  logic [7:0] cmd_rate   [3];
  logic [7:0] duty_o     [3];
  logic       busy_o     [3];
  logic       done_o     [3];
`ifdef PWM_RAMP_ABORT_EN
  logic       abort_i;
`endif

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      pwm_ramp_ctrl #(
        .WIDTH (8),
        .STEP  ((gi == 0) ? 1 : ((gi == 1) ? 8 : 16)),
        .RATE_W(8)
      ) u_dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .ena        (ena),
        .period_tick(period_tick),
        .cmd_valid  (cmd_valid[gi]),
        .cmd_ready  (cmd_ready[gi]),
        .cmd_target (cmd_target[gi]),
        .cmd_rate   (cmd_rate[gi]),
`ifdef PWM_RAMP_ABORT_EN
        .abort_i    (abort_i),
`endif
        .duty_o     (duty_o[gi]),
        .busy_o     (busy_o[gi]),
        .done_o     (done_o[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [7:0] duty;
    int         tick_no;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         m_ticks  = 0;
  int         ndone    = 0;
  logic       exp_done = 1'b0;
  logic [7:0] m_duty [3];
  logic [7:0] prev   [3];

  function automatic int step_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 8 : 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Called just after a falling edge: compare the active instance with the scoreboard.
  task automatic sample(input int idx);
    exp_t e;
    if (sb.size() != 0 && duty_o[idx] !== prev[idx]) begin
      e = sb.pop_front();
      chk("duty_step", 32'(duty_o[idx]), 32'(e.duty));
      chk("step_tick", 32'(m_ticks), 32'(e.tick_no));
      if (sb.size() == 0) exp_done = 1'b1;
    end else begin
      chk("duty_hold", 32'(duty_o[idx]), 32'(prev[idx]));
    end
    chk("busy", 32'(busy_o[idx]), 32'(sb.size() != 0));
    chk("done", 32'(done_o[idx]), 32'(exp_done));
    if (exp_done) ndone++;
    exp_done  = 1'b0;
    prev[idx] = duty_o[idx];
  endtask

  // Issue n period ticks, one every 4 cycles, sampling every cycle.
  task automatic run_ticks(input int idx, input int n);
    for (int t = 0; t < n; t++) begin
      period_tick = 1'b1;
      if (ena) m_ticks++;
      @(negedge clk);
      period_tick = 1'b0;
      sample(idx);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        sample(idx);
      end
    end
  endtask

  // Build the expected duty sequence, then perform the handshake.
  task automatic do_cmd(input int idx, input logic [7:0] tgt, input logic [7:0] rate,
                        output int nticks);
    int d, st, re, k;
    st = step_of(idx);
    re = (rate == 8'd0) ? 1 : int'(rate);
    d  = int'(m_duty[idx]);
    k  = 0;
    while (d != int'(tgt)) begin
      if (((int'(tgt) > d) ? (int'(tgt) - d) : (d - int'(tgt))) <= st) d = int'(tgt);
      else if (int'(tgt) > d) d = d + st;
      else d = d - st;
      k++;
      sb.push_back('{duty: 8'(d), tick_no: k * re});
    end
    nticks      = k * re;
    m_duty[idx] = tgt;
    ndone       = 0;
    cmd_valid[idx]  = 1'b1;
    cmd_target[idx] = tgt;
    cmd_rate[idx]   = rate;
    chk("cmd_ready_idle", 32'(cmd_ready[idx]), 32'd1);
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
    m_ticks        = 0;
    if (k == 0) exp_done = 1'b1;
    sample(idx);
  endtask

  task automatic finish_cmd(input int idx, input logic [7:0] tgt);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    chk("final_duty", 32'(duty_o[idx]), 32'(tgt));
    chk("done_count", 32'(ndone), 32'd1);
    chk("cmd_ready_after", 32'(cmd_ready[idx]), 32'd1);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    ena = 1'b1;
    period_tick = 1'b0;
`ifdef PWM_RAMP_ABORT_EN
    abort_i = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_target[i] = 8'd0;
      cmd_rate[i] = 8'd0;
      m_duty[i] = 8'd0;
      prev[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_duty", 32'(duty_o[i]), 32'd0);
      chk("rst_busy", 32'(busy_o[i]), 32'd0);
      chk("rst_done", 32'(done_o[i]), 32'd0);
      chk("rst_ready", 32'(cmd_ready[i]), 32'd1);
    end

    // STEP=8: ramp up to 100, then down to 10 at rate 3 (last step clamped).
    do_cmd(1, 8'd100, 8'd1, n); run_ticks(1, n); finish_cmd(1, 8'd100);
    $display("txn inst1 target=100 rate=1 duty=%0d", duty_o[1]);
    do_cmd(1, 8'd10, 8'd3, n); run_ticks(1, n); finish_cmd(1, 8'd10);
    $display("txn inst1 target=10 rate=3 duty=%0d", duty_o[1]);

    // STEP=16: reach 250, then 255 with rate 0 treated as 1.
    do_cmd(2, 8'd250, 8'd1, n); run_ticks(2, n); finish_cmd(2, 8'd250);
    $display("txn inst2 target=250 rate=1 duty=%0d", duty_o[2]);
    do_cmd(2, 8'd255, 8'd0, n); chk("rate0_ticks", 32'(n), 32'd1);
    run_ticks(2, n); finish_cmd(2, 8'd255);
    $display("txn inst2 target=255 rate=0 duty=%0d", duty_o[2]);

    // STEP=1: 0 -> 100 at rate 1.
    do_cmd(0, 8'd100, 8'd1, n); chk("ramp100_ticks", 32'(n), 32'd100);
    run_ticks(0, n); finish_cmd(0, 8'd100);
    $display("txn inst0 target=100 rate=1 duty=%0d", duty_o[0]);

    // Down to 42, then a same-value command.
    do_cmd(0, 8'd42, 8'd1, n); run_ticks(0, n); finish_cmd(0, 8'd42);
    do_cmd(0, 8'd42, 8'd5, n); run_ticks(0, 1); finish_cmd(0, 8'd42);
    $display("txn inst0 same-value target=42 duty=%0d", duty_o[0]);

    // Pause for 20 ticks with the counter mid-count, then resume.
    do_cmd(0, 8'd60, 8'd2, n);
    run_ticks(0, 11);
    chk("pause_duty", 32'(duty_o[0]), 32'd47);
    ena = 1'b0;
    run_ticks(0, 20);
    chk("pause_ready", 32'(cmd_ready[0]), 32'd0);
    chk("pause_frozen", 32'(duty_o[0]), 32'd47);
    ena = 1'b1;
    run_ticks(0, n - 11); finish_cmd(0, 8'd60);
    $display("txn inst0 target=60 rate=2 paused duty=%0d", duty_o[0]);

    // Reset mid-ramp abandons the command.
    do_cmd(0, 8'd200, 8'd1, n);
    run_ticks(0, 5);
    chk("pre_rst_duty", 32'(duty_o[0]), 32'd65);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_duty", 32'(duty_o[0]), 32'd0);
    chk("midrst_ready", 32'(cmd_ready[0]), 32'd1);
    chk("midrst_busy", 32'(busy_o[0]), 32'd0);
    chk("midrst_done", 32'(done_o[0]), 32'd0);
    sb.delete();
    m_duty[0] = 8'd0;
    prev[0] = 8'd0;
    $display("txn inst0 reset mid-ramp duty=%0d", duty_o[0]);

`ifdef PWM_RAMP_ABORT_EN
    // Abort during the ramp to 200 at duty 57.
    do_cmd(0, 8'd200, 8'd1, n);
    run_ticks(0, 57);
    chk("pre_abort_duty", 32'(duty_o[0]), 32'd57);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_duty", 32'(duty_o[0]), 32'd0);
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_done", 32'(done_o[0]), 32'd0);
    chk("abort_ready", 32'(cmd_ready[0]), 32'd1);
    sb.delete();
    m_duty[0] = 8'd0;
    prev[0] = 8'd0;
    run_ticks(0, 2);
    $display("txn inst0 abort at 57 duty=%0d", duty_o[0]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer that sits in front of the 8-bit PWM generator and drives its duty input.
- Accepts a target duty plus ramp rate over a valid/ready command interface.
- Steps the applied duty toward the target once every N PWM periods, counted on the generator's period tick. This gives soft-start and soft-stop for motor and LED loads.
- Reports busy and completion.

Parameters:
WIDTH, 8, width of duty values and of the target.
STEP, 1, duty increment or decrement applied per ramp step; must be at least 1 and below 2^WIDTH.
RATE_W, 8, width of the rate field and of the internal period-tick counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
ena  input  1  global enable; 0 freezes ramp progress
period_tick  input  1  one-cycle pulse from PWM generator at the start of each PWM period
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_target  input  WIDTH  requested final duty
cmd_rate  input  RATE_W  number of PWM periods between steps; 0 is treated as 1
duty_o  output  WIDTH  duty value applied to the PWM generator comparator
busy_o  output  1  high while ramping
done_o  output  1  one-cycle pulse when duty_o reaches the target

Behaviour:
- Reset: rst_i sampled on the clk edge only. After reset:
  - duty_o=0, busy_o=0, done_o=0, cmd_ready=1.
  - State is IDLE; tick counter=0; target and rate registers=0.
  - Reset mid-ramp drops duty_o to 0 on the next edge and abandons the command.
- States: IDLE, RAMP, DONE.
- IDLE:
  - cmd_ready = ena.
  - Handshake on cmd_valid & cmd_ready at an edge: capture target, capture rate (0 mapped to 1), clear tick counter.
  - If the captured target equals duty_o, go to DONE; otherwise go to RAMP.
- RAMP:
  - cmd_ready=0 and busy_o=1. New commands are held off; the requester keeps cmd_valid asserted.
  - The counter increments on each period_tick while ena=1.
  - When the counter reaches rate-1 and a period_tick arrives, the counter clears and duty_o moves one step toward the target.
  - Step rule: if |target-duty_o| <= STEP, duty_o = target exactly; otherwise duty_o = duty_o ± STEP. There is no overshoot and no wrap past 0 or 2^WIDTH-1. Arithmetic uses WIDTH+1 bits internally.
  - When duty_o becomes equal to target, go to DONE on the same edge as the final step.
  - period_tick with ena=0 is ignored and the counter holds. Deasserting ena mid-ramp pauses; reasserting resumes with the counter intact.
- DONE:
  - done_o=1 and busy_o=0 for exactly one cycle, then IDLE.
  - cmd_ready=0 in DONE, so back-to-back commands incur one idle cycle.
- Latency:
  - Command accept to first duty change: rate period_ticks.
  - Full ramp: ceil(|target-start|/STEP) × rate ticks.
  - Same-value command: done_o is asserted the cycle after the handshake.
- duty_o changes only on clk edges, for direct registered connection to the generator comparator.

Optional Feature:
- Macro: PWM_RAMP_ABORT_EN.
- With the macro: an extra input abort_i (1 bit) is present.
  - abort_i=1 in RAMP forces duty_o=0 and the state to IDLE on the next edge. No done_o is asserted.
  - abort_i in IDLE or DONE forces duty_o=0 only.
  - Reset has priority over abort.
- Without the macro: the port is absent, and ramps complete or stop only on reset.

Test Plan:
1. Reset, then cmd target=100, rate=1, STEP=1, period_tick every 4 cycles:
   - duty_o increments by 1 per tick.
   - Exactly 100 ticks to reach 100; done_o pulses once; busy_o falls with it.
2. From duty 100, cmd target=10, rate=3, STEP=8:
   - duty_o sequence 92,84,…,12,10 (last step clamped).
   - One change every 3 ticks; no underflow.
3. cmd target=255, rate=0, STEP=16 from 250: rate treated as 1; duty_o goes 250→255 on the first tick; no wrap to 10.
4. Same-value command (target==duty_o=42): done_o the cycle after handshake; duty_o unchanged; busy_o stays 0.
5. Mid-ramp behaviour:
   - Drop ena for 20 ticks: duty_o and counter frozen; resumes correctly.
   - Assert rst_i mid-ramp: duty_o=0 and cmd_ready=1 on the next edge.
6. With PWM_RAMP_ABORT_EN:
   - abort_i during the ramp to 200 at duty 57 gives duty_o=0, IDLE, and no done_o.
   - Without the macro, the same bench compiles with abort_i absent.
